lpm_hint_evaluation: RTL and testbench

Streaming parser for LPM hint strings such as "LPM_REMAINDERPOSITIVE=TRUE,MAXIMIZE_SPEED=6". It receives a comma-separated list of NAME=VALUE pairs one ASCII character per cycle and returns the value bound to a queried name. LPM arithmetic wrappers such as lpm_divide use it to resolve options like LPM_REMAINDERPOSITIVE, so they can be configured at run time or elaboration time.

---
 rtl/lpm_hint_evaluation.sv | 147 ++++++++++++++
 tb/tb_lpm_hint_evaluation.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpm_hint_evaluation.sv
// Streaming NAME=VALUE hint parser: returns the value bound to a queried name.
// Optional build macro LPM_HINT_CASE_FOLD_EN folds a-z to A-Z before name comparison.
module lpm_hint_evaluation #(
    parameter int MAX_NAME_CHARS  = 24,
    parameter int MAX_VALUE_CHARS = 8
) (
    input  logic                         clock,
    input  logic                         aclr_n,
    input  logic                         start,
    input  logic [8*MAX_NAME_CHARS-1:0]  query_name,
    input  logic                         char_valid,
    input  logic [7:0]                   char_in,
    input  logic                         char_last,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic [8*MAX_VALUE_CHARS-1:0] value
);

    localparam int NW = 8 * MAX_NAME_CHARS;
    localparam int VW = 8 * MAX_VALUE_CHARS;
    localparam int CW = $clog2(MAX_NAME_CHARS + 1);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_EQ    = 8'h3D;

    logic [NW-1:0] query_q, name_q;
    logic [CW-1:0] name_cnt;
    logic          name_ovf, seen_eq, pair_match;
    logic [VW-1:0] val_q;

    logic [NW-1:0] b_query, b_name, n_name;
    logic [CW-1:0] b_cnt, n_cnt;
    logic          b_ovf, b_eq, b_match, n_ovf, n_eq, n_match;
    logic [VW-1:0] b_val, n_val;
    logic          accept, pair_end;

    function automatic logic [NW-1:0] fold_name(input logic [NW-1:0] s);
`ifdef LPM_HINT_CASE_FOLD_EN
        logic [NW-1:0] r;
        r = s;
        for (int i = 0; i < MAX_NAME_CHARS; i++) begin
            if (s[8*i +: 8] >= 8'h61 && s[8*i +: 8] <= 8'h7A)
                r[8*i +: 8] = s[8*i +: 8] - 8'h20;
        end
        return r;
`else
        return s;
`endif
    endfunction

    // start wipes the pair state before the same-cycle character is applied
    always_comb begin
        b_query = start ? query_name : query_q;
        b_name  = start ? '0 : name_q;
        b_cnt   = start ? '0 : name_cnt;
        b_ovf   = start ? 1'b0 : name_ovf;
        b_eq    = start ? 1'b0 : seen_eq;
        b_match = start ? 1'b0 : pair_match;
        b_val   = start ? '0 : val_q;

        n_name   = b_name;
        n_cnt    = b_cnt;
        n_ovf    = b_ovf;
        n_eq     = b_eq;
        n_match  = b_match;
        n_val    = b_val;
        pair_end = 1'b0;
        accept   = char_valid && (busy || start);

        if (accept) begin
            case (char_in)
                CH_SPACE: ;
                CH_COMMA: pair_end = 1'b1;
                CH_EQ: begin
                    if (!b_eq) begin
                        n_eq    = 1'b1;
                        n_match = !b_ovf && (b_cnt != '0) &&
                                  (fold_name(b_name) == fold_name(b_query));
                    end
                end
                default: begin
                    if (!b_eq) begin
                        n_name = {b_name[NW-9:0], char_in};
                        if (b_cnt == CW'(MAX_NAME_CHARS))
                            n_ovf = 1'b1;
                        else
                            n_cnt = b_cnt + 1'b1;
                    end else begin
                        n_val = {b_val[VW-9:0], char_in};
                    end
                end
            endcase
            if (char_last)
                pair_end = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            value      <= '0;
            query_q    <= '0;
            name_q     <= '0;
            name_cnt   <= '0;
            name_ovf   <= 1'b0;
            seen_eq    <= 1'b0;
            pair_match <= 1'b0;
            val_q      <= '0;
        end else begin
            done    <= 1'b0;
            query_q <= b_query;
            if (start) begin
                busy  <= 1'b1;
                found <= 1'b0;
                value <= '0;
            end
            if (pair_end) begin
                if (n_eq && n_match) begin
                    found <= 1'b1;
                    value <= n_val;
                end
                name_q     <= '0;
                name_cnt   <= '0;
                name_ovf   <= 1'b0;
                seen_eq    <= 1'b0;
                pair_match <= 1'b0;
                val_q      <= '0;
            end else begin
                name_q     <= n_name;
                name_cnt   <= n_cnt;
                name_ovf   <= n_ovf;
                seen_eq    <= n_eq;
                pair_match <= n_match;
                val_q      <= n_val;
            end
            if (accept && char_last) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lpm_hint_evaluation.sv
// Bench for lpm_hint_evaluation: directed and random hint strings against a string-level model.
module tb_lpm_hint_evaluation;

    logic         clock = 1'b0;
    logic         aclr_n;
    logic         start;
    logic [191:0] query_name;
    logic         char_valid;
    logic [7:0]   char_in;
    logic         char_last;
    logic         busy, done, found;
    logic [63:0]  value;

    int vectors = 0;
    int miscompares = 0;

    string names[8] = '{"A", "B", "AB", "lpm_x", "LPM_X", "",
                        "ABCDEFGHIJKLMNOPQRSTUVWX", "ABCDEFGHIJKLMNOPQRSTUVWXY"};
    string queries[7] = '{"A", "B", "AB", "lpm_x", "LPM_X",
                          "ABCDEFGHIJKLMNOPQRSTUVWX", "BCDEFGHIJKLMNOPQRSTUVWXY"};
    string vpool = "ABCDEFGHIJ0123456789xyz_";

    always #5 clock = ~clock;

    lpm_hint_evaluation dut (
        .clock(clock), .aclr_n(aclr_n), .start(start), .query_name(query_name),
        .char_valid(char_valid), .char_in(char_in), .char_last(char_last),
        .busy(busy), .done(done), .found(found), .value(value)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic string fold(input string s);
`ifdef LPM_HINT_CASE_FOLD_EN
        return s.toupper();
`else
        return s;
`endif
    endfunction

    function automatic logic [191:0] pack_q(input string s);
        logic [191:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[8*(s.len()-1-i) +: 8] = s.getc(i);
        return r;
    endfunction

    // Keep only the rightmost 8 characters, right-justified
    function automatic logic [63:0] pack_v(input string s);
        logic [63:0] r = '0;
        int first = (s.len() > 8) ? s.len() - 8 : 0;
        for (int i = first; i < s.len(); i++) r[8*(s.len()-1-i) +: 8] = s.getc(i);
        return r;
    endfunction

    function automatic void model(input string q, input string h,
                                  output logic f, output logic [63:0] v);
        string nm = "";
        string vl = "";
        bit    eq = 0;
        f = 0;
        v = '0;
        for (int i = 0; i <= h.len(); i++) begin
            bit  pend = (i == h.len());
            byte c;
            if (!pend) begin
                c = h.getc(i);
                if (c == ",") pend = 1;
                else if (c == " ") ;
                else if (c == "=") eq = 1;
                else if (!eq) nm = $sformatf("%s%c", nm, c);
                else vl = $sformatf("%s%c", vl, c);
            end
            if (pend) begin
                if (eq && nm.len() > 0 && nm.len() <= 24 && fold(nm) == fold(q)) begin
                    f = 1;
                    v = pack_v(vl);
                end
                nm = "";
                vl = "";
                eq = 0;
            end
        end
    endfunction

    function automatic string sp();
        return ($urandom_range(0, 4) == 0) ? " " : "";
    endfunction

    function automatic string rand_hint();
        string s = "";
        int np = $urandom_range(1, 4);
        for (int p = 0; p < np; p++) begin
            if (p > 0) s = {s, ","};
            s = {s, sp(), names[$urandom_range(0, 7)], sp()};
            if ($urandom_range(0, 7) != 0) begin
                int vlen = $urandom_range(0, 11);
                s = {s, "=", sp()};
                for (int k = 0; k < vlen; k++)
                    s = $sformatf("%s%c", s, vpool.getc($urandom_range(0, vpool.len()-1)));
                if ($urandom_range(0, 5) == 0) s = {s, "=Q"};
                s = {s, sp()};
            end
        end
        return s;
    endfunction

    task automatic put(input string h, input int i);
        char_valid = 1'b1;
        char_in    = h.getc(i);
        char_last  = (i == h.len() - 1);
    endtask

    task automatic idle_char();
        char_valid = 1'b0;
        char_in    = 8'($urandom);
        char_last  = 1'($urandom);
    endtask

    task automatic run(input string q, input string h, input bit wsc, input bit gaps);
        logic        ef;
        logic [63:0] ev;
        int          idx = 0;
        model(q, h, ef, ev);
        @(negedge clock);
        start      = 1'b1;
        query_name = pack_q(q);
        if (wsc) begin
            put(h, 0);
            idx = 1;
        end else idle_char();
        while (idx < h.len()) begin
            @(negedge clock);
            start      = 1'b0;
            query_name = {6{$urandom()}};
            chk({"busy_mid ", h}, 64'(busy), 64'd1);
            chk({"done_early ", h}, 64'(done), 64'd0);
            if (gaps && $urandom_range(0, 3) == 0) idle_char();
            else begin
                put(h, idx);
                idx++;
            end
        end
        @(negedge clock);
        start = 1'b0;
        idle_char();
        chk({"done ", h}, 64'(done), 64'd1);
        chk({"busy_end ", h}, 64'(busy), 64'd0);
        chk({"found ", q, " in ", h}, 64'(found), 64'(ef));
        chk({"value ", q, " in ", h}, value, ev);
        @(negedge clock);
        chk({"done_pulse ", h}, 64'(done), 64'd0);
        chk({"found_hold ", h}, 64'(found), 64'(ef));
        chk({"value_hold ", h}, value, ev);
    endtask

    task automatic partial(input string q, input string h, input int n);
        @(negedge clock);
        start      = 1'b1;
        query_name = pack_q(q);
        idle_char();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            start = 1'b0;
            chk("partial_busy", 64'(busy), 64'd1);
            chk("partial_done", 64'(done), 64'd0);
            char_valid = 1'b1;
            char_in    = h.getc(i);
            char_last  = 1'b0;
        end
        @(negedge clock);
        idle_char();
        chk("partial_busy_after", 64'(busy), 64'd1);
        chk("partial_done_after", 64'(done), 64'd0);
    endtask

    initial begin
        aclr_n     = 1'b0;
        start      = 1'b0;
        query_name = '0;
        idle_char();
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_value", value, 64'd0);
        @(negedge clock);
        aclr_n = 1'b1;

        run("LPM_REMAINDERPOSITIVE", "LPM_REMAINDERPOSITIVE=TRUE", 0, 0);
        chk("basic_true", value, 64'h0000_0000_5452_5545);
        run("B", "A=1, B = FALSE ,C=3", 1, 0);
        run("D", "A=1, B = FALSE ,C=3", 0, 1);
        run("X", "X=1,X=22", 0, 0);
        chk("dup_22", value, 64'h3232);
        run("X", "X=", 1, 0);
        chk("empty_found", 64'(found), 64'd1);
        run("X", "X=ABCDEFGHIJ", 0, 1);
        chk("long_value", value, 64'h4344_4546_4748_494A);
        run("lpm_x", "LPM_X=ON", 0, 0);
`ifdef LPM_HINT_CASE_FOLD_EN
        chk("fold_found", 64'(found), 64'd1);
`else
        chk("fold_found", 64'(found), 64'd0);
`endif
        run("X", "X=1,Y=2,X=3=4", 1, 1);
        run("A", "A=7,", 0, 0);
        run("A", "B=1,A", 0, 0);
        run("A", "A", 1, 0);

        // Characters while idle must not disturb the held result
        run("Z", "Z=9", 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            char_valid = 1'b1;
            char_in    = "=";
            char_last  = (i == 2);
            chk("idle_done", 64'(done), 64'd0);
        end
        @(negedge clock);
        idle_char();
        chk("idle_done_end", 64'(done), 64'd0);
        chk("idle_found", 64'(found), 64'd1);
        chk("idle_value", value, 64'h39);

        // Asynchronous reset while a parse is in flight
        partial("X", "X=1,Y", 4);
        #2 aclr_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_found", 64'(found), 64'd0);
        chk("arst_value", value, 64'd0);
        @(negedge clock);
        aclr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            char_valid = 1'b1;
            char_in    = (i == 1) ? "=" : "X";
            char_last  = (i == 3);
            @(negedge clock);
            chk("post_rst_busy", 64'(busy), 64'd0);
            chk("post_rst_done", 64'(done), 64'd0);
            chk("post_rst_found", 64'(found), 64'd0);
        end
        idle_char();

        // Reset while idle with a held result
        run("Q", "Q=77", 0, 0);
        #2 aclr_n = 1'b0;
        #1;
        chk("idle_rst_found", 64'(found), 64'd0);
        chk("idle_rst_value", value, 64'd0);
        @(negedge clock);
        aclr_n = 1'b1;

        // Restart mid-parse: the aborted parse never raises done
        partial("X", "X=1,X=2", 5);
        run("Y", "X=4,Y=5", 0, 0);
        chk("restart_value", value, 64'h35);

        for (int t = 0; t < 60; t++)
            run(queries[$urandom_range(0, 6)], rand_hint(), 1'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
